spi_final: RTL and testbench

SPI_FINAL -- requirements
Module: spi_final

---
 rtl/spi_final.sv | 188 ++++++++++++++++++
 tb/tb_spi_final.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spi_final.sv
// spi_final: byte FIFO feeding a serial transmitter on spi_mosi_out.
// Frame: start 0, data bits MSB first, optional odd parity, stop 1; each bit
// lasts CLK_DIV cycles of m_clk. A 0->1 edge on data_av enqueues data_in.
// Optional feature macro: SPI_FINAL_PARITY_EN adds an odd-parity bit after data bit 0.
// n_reset is synchronous and active-high despite its name.
module spi_final #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       m_clk,
  input  logic       n_reset,
  input  logic [7:0] data_in,
  input  logic       data_av,
  output logic       spi_mosi_out
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
`ifdef SPI_FINAL_PARITY_EN
  localparam logic [2:0] StPar   = 3'd3;
`endif
  localparam logic [2:0] StStop  = 3'd4;

  logic          av_q, av_d;
  logic [2:0]    state_q, state_d;
  logic [7:0]    div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          mosi_q, mosi_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
`ifdef SPI_FINAL_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic       write;
  logic       push;
  logic       pop;
  logic       fifo_empty;
  logic       bit_end;
  logic [7:0] head;

  // Write detection and FIFO bookkeeping; full test uses the pre-edge count so
  // a same-edge pop never makes room for a simultaneous write.
  always_comb begin
    av_d       = data_av;
    write      = data_av & ~av_q;
    push       = write & (count_q != CW'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    head       = mem_q[rd_ptr_q];
    mem_d      = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = data_in;
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Transmitter FSM: the divider restarts at every bit boundary.
  always_comb begin
    bit_end  = (div_q == 8'(CLK_DIV - 1));
    state_d  = state_q;
    div_d    = bit_end ? 8'd0 : div_q + 8'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    mosi_d   = mosi_q;
    pop      = 1'b0;
`ifdef SPI_FINAL_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        mosi_d = 1'b1;
        div_d  = 8'd0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_d  = head;
          mosi_d   = 1'b0;
          state_d  = StStart;
`ifdef SPI_FINAL_PARITY_EN
          parity_d = ~^head;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          mosi_d  = shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = 3'd0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef SPI_FINAL_PARITY_EN
            state_d = StPar;
            mosi_d  = parity_q;
`else
            state_d = StStop;
            mosi_d  = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            mosi_d  = shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
          end
        end
      end
`ifdef SPI_FINAL_PARITY_EN
      StPar: begin
        if (bit_end) begin
          state_d = StStop;
          mosi_d  = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            // Back-to-back frame: no idle gap between stop and next start.
            pop      = 1'b1;
            shift_d  = head;
            mosi_d   = 1'b0;
            state_d  = StStart;
`ifdef SPI_FINAL_PARITY_EN
            parity_d = ~^head;
`endif
          end else begin
            mosi_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        mosi_d  = 1'b1;
        div_d   = 8'd0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge m_clk) begin
    if (n_reset) begin
      av_q     <= 1'b0;
      state_q  <= StIdle;
      div_q    <= 8'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      mosi_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 8'd0;
      end
`ifdef SPI_FINAL_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      av_q     <= av_d;
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      mosi_q   <= mosi_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
`ifdef SPI_FINAL_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign spi_mosi_out = mosi_q;

endmodule

// File: tb/tb_spi_final.sv
// Directed bench for spi_final (CLK_DIV=4, FIFO_DEPTH=8). Each scenario fills
// per-cycle stimulus tables and an expected line queue (1 when queue empty),
// then checks spi_mosi_out 1 time unit after every rising edge.
module tb_spi_final;

  localparam int MaxCyc = 600;

  logic       m_clk = 1'b0;
  logic       n_reset;
  logic [7:0] data_in;
  logic       data_av;
  logic       spi_mosi_out;

  int checks = 0;
  int errors = 0;

  logic       av_s  [MaxCyc];
  logic       rst_s [MaxCyc];
  logic [7:0] din_s [MaxCyc];
  bit         exp_q [$];

  always #5 m_clk = ~m_clk;

  spi_final #(
    .CLK_DIV   (4),
    .FIFO_DEPTH(8)
  ) dut (
    .m_clk       (m_clk),
    .n_reset     (n_reset),
    .data_in     (data_in),
    .data_av     (data_av),
    .spi_mosi_out(spi_mosi_out)
  );

  task automatic clear_sched();
    for (int i = 0; i < MaxCyc; i++) begin
      av_s[i]  = 1'b0;
      rst_s[i] = 1'b0;
      din_s[i] = 8'h00;
    end
    exp_q.delete();
  endtask

  task automatic push_bits(input bit v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  // Start 0, data MSB first, optional odd parity, stop 1; 4 cycles per bit.
  task automatic push_frame(input logic [7:0] b);
    push_bits(1'b0, 4);
    for (int i = 7; i >= 0; i--) push_bits(bit'(b[i]), 4);
`ifdef SPI_FINAL_PARITY_EN
    push_bits(bit'(~^b), 4);
`endif
    push_bits(1'b1, 4);
  endtask

  task automatic run(input string tag, input int n);
    bit e;
    for (int c = 0; c < n; c++) begin
      n_reset = rst_s[c];
      data_av = av_s[c];
      data_in = din_s[c];
      @(posedge m_clk);
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
      checks++;
      assert (spi_mosi_out === e) else begin
        errors++;
        $error("FAIL %s cycle %0d: mosi=%b expected %b", tag, c, spi_mosi_out, e);
      end
    end
  endtask

  initial begin
    n_reset = 1'b1;
    data_av = 1'b0;
    data_in = 8'h00;

    // Reset state: line high; a data_av pulse during reset is not captured.
    clear_sched();
    for (int i = 0; i < 4; i++) rst_s[i] = 1'b1;
    av_s[2]  = 1'b1;
    din_s[2] = 8'h55;
    run("reset_idle", 60);

    // data_av already high across reset release counts as a write right after.
    clear_sched();
    for (int i = 0; i < 3; i++) rst_s[i] = 1'b1;
    for (int i = 0; i < 6; i++) av_s[i] = 1'b1;
    din_s[3] = 8'h96;
    push_bits(1'b1, 4);
    push_frame(8'h96);
    run("first_after_reset", 60);

    // Single pulse 0xA5: low from the edge after the write.
    clear_sched();
    av_s[0]  = 1'b1;
    din_s[0] = 8'hA5;
    push_bits(1'b1, 1);
    push_frame(8'hA5);
    run("frame_a5", 60);

    // data_av held 5 cycles, data_in changing afterwards: one frame of 0x3C.
    clear_sched();
    for (int i = 0; i < 5; i++) begin
      av_s[i]  = 1'b1;
      din_s[i] = 8'hFF;
    end
    din_s[0] = 8'h3C;
    push_bits(1'b1, 1);
    push_frame(8'h3C);
    run("hold5_3c", 70);

    // Ten pulses 2 cycles apart: 0x01..0x09 back to back, 0x0A dropped.
    clear_sched();
    for (int k = 0; k < 10; k++) begin
      av_s[2*k]    = 1'b1;
      din_s[2*k]   = 8'(k + 1);
      din_s[2*k+1] = 8'hEE;
    end
    push_bits(1'b1, 1);
    for (int k = 1; k <= 9; k++) push_frame(8'(k));
    run("fifo_full", 420);

    // Reset during data bit 3 of 0xFF with two bytes queued: frame aborted,
    // queue discarded, line stays high after release.
    clear_sched();
    av_s[0]  = 1'b1;
    din_s[0] = 8'hFF;
    av_s[2]  = 1'b1;
    din_s[2] = 8'h11;
    av_s[4]  = 1'b1;
    din_s[4] = 8'h22;
    rst_s[22] = 1'b1;
    rst_s[23] = 1'b1;
    push_bits(1'b1, 1);
    push_bits(1'b0, 4);
    run("reset_mid_frame", 150);

`ifdef SPI_FINAL_PARITY_EN
    // 0x07 has three ones -> parity 0; 0x03 has two -> parity 1; 44-cycle frames.
    clear_sched();
    av_s[0]  = 1'b1;
    din_s[0] = 8'h07;
    push_bits(1'b1, 1);
    push_bits(1'b0, 4);
    push_bits(1'b0, 20);
    push_bits(1'b1, 12);
    push_bits(1'b0, 4);
    push_bits(1'b1, 4);
    run("parity_07", 60);

    clear_sched();
    av_s[0]  = 1'b1;
    din_s[0] = 8'h03;
    push_bits(1'b1, 1);
    push_bits(1'b0, 4);
    push_bits(1'b0, 24);
    push_bits(1'b1, 8);
    push_bits(1'b1, 4);
    push_bits(1'b1, 4);
    run("parity_03", 60);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
